// File: rtl/ik_swift_sequencer.sv
// Iteration controller for the ik_swift IK core: resets, enables and re-feeds the core
// until the joint deltas converge, the iteration cap is hit, the watchdog fires or the host aborts.
module ik_swift_sequencer #(
    parameter int W       = 36,
    parameter int N       = 6,
    parameter int TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic [7:0]     max_iter,
    input  logic [W-1:0]   epsilon,
    input  logic [N*W-1:0] dh_init,
    output logic           core_en,
    output logic           core_rst,
    output logic [N*W-1:0] core_dh_in,
    input  logic           core_done,
    input  logic [N*W-1:0] core_delta,
    input  logic [N*W-1:0] core_dh_out,
    output logic [N*W-1:0] dh_result,
    output logic [7:0]     iter_count,
    output logic           busy,
    output logic           solved,
    output logic           fail,
    output logic           timeout,
    output logic           done_pulse
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [W-1:0]    MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT, S_CHECK, S_DONE, S_ABORT} state_t;

    state_t           state_q, state_d;
    logic [N*W-1:0]   dh_reg_q, dh_reg_d, dh_result_q, dh_result_d, delta_q, delta_d;
    logic [7:0]       max_iter_q, max_iter_d, iter_q, iter_d, iter_inc;
    logic [W-1:0]     eps_q, eps_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             solved_q, solved_d, fail_q, fail_d, timeout_q, timeout_d;
    logic             core_en_q, core_en_d, core_rst_q, core_rst_d;
    logic             busy_q, busy_d, done_pulse_q, done_pulse_d;
    logic             converged;

    // The most negative code has no positive counterpart, so it never converges.
    function automatic logic within_eps(input logic signed [W-1:0] d, input logic [W-1:0] eps);
        logic [W-1:0] neg;
        logic [W-1:0] mag;
        neg = $unsigned(-d);
        mag = d[W-1] ? neg : $unsigned(d);
        if ($unsigned(d) == MOST_NEG)
            return 1'b0;
        return mag < eps;
    endfunction

    always_comb begin
        converged = 1'b1;
        for (int i = 0; i < N; i++)
            if (!within_eps($signed(delta_q[i*W +: W]), eps_q))
                converged = 1'b0;
        iter_inc = (iter_q == 8'hFF) ? 8'hFF : iter_q + 8'd1;
    end

    always_comb begin
        state_d     = state_q;
        dh_reg_d    = dh_reg_q;
        dh_result_d = dh_result_q;
        delta_d     = delta_q;
        max_iter_d  = max_iter_q;
        eps_d       = eps_q;
        iter_d      = iter_q;
        wd_d        = wd_q;
        solved_d    = solved_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE: if (start) begin
                dh_reg_d   = dh_init;
                max_iter_d = (max_iter == 8'd0) ? 8'd1 : max_iter;
                eps_d      = epsilon;
                iter_d     = 8'd0;
                wd_d       = '0;
                solved_d   = 1'b0;
                fail_d     = 1'b0;
                timeout_d  = 1'b0;
                state_d    = S_CLEAR;
            end
            S_CLEAR: begin
                wd_d    = '0;
                state_d = abort ? S_ABORT : S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (core_done) begin
                    dh_reg_d    = core_dh_out;
                    dh_result_d = core_dh_out;
                    delta_d     = core_delta;
                    state_d     = S_CHECK;
                end else if (wd_q == WD_LAST) begin
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else begin
                    iter_d = iter_inc;
                    if (converged) begin
                        solved_d = 1'b1;
                        state_d  = S_DONE;
                    end else if (iter_inc >= max_iter_q) begin
                        fail_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Outputs are decoded from the next state so they line up with the registered state.
        core_en_d    = (state_d == S_WAIT);
        core_rst_d   = (state_d == S_CLEAR) || (state_d == S_ABORT);
        busy_d       = (state_d != S_IDLE);
        done_pulse_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dh_reg_q     <= '0;
            dh_result_q  <= '0;
            delta_q      <= '0;
            max_iter_q   <= '0;
            eps_q        <= '0;
            iter_q       <= '0;
            wd_q         <= '0;
            solved_q     <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            core_en_q    <= 1'b0;
            core_rst_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dh_reg_q     <= dh_reg_d;
            dh_result_q  <= dh_result_d;
            delta_q      <= delta_d;
            max_iter_q   <= max_iter_d;
            eps_q        <= eps_d;
            iter_q       <= iter_d;
            wd_q         <= wd_d;
            solved_q     <= solved_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            core_en_q    <= core_en_d;
            core_rst_q   <= core_rst_d;
            busy_q       <= busy_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign core_en    = core_en_q;
    assign core_rst   = core_rst_q;
    assign core_dh_in = dh_reg_q;
    assign dh_result  = dh_result_q;
    assign iter_count = iter_q;
    assign busy       = busy_q;
    assign solved     = solved_q;
    assign fail       = fail_q;
    assign timeout    = timeout_q;
    assign done_pulse = done_pulse_q;
endmodule
